// File: rtl/keypad_debounce_if.sv
// Keypad-side and consumer-side signals of the keypad debouncer.
// The debouncer connects through the master modport and its environment through the slave modport.
interface keypad_debounce_if #(
    parameter int ROWS = 5,
    parameter int COLS = 4
);
    localparam int CW = $clog2(ROWS * COLS);

    logic [ROWS-1:0] k_row;
    logic [COLS-1:0] k_col;
    logic            key_ack;
    logic            clr_ovr;
    logic [ROWS-1:0] row_out;
    logic [COLS-1:0] col_out;
    logic            key_valid;
    logic [CW-1:0]   key_code;
    logic            pressed;
    logic            overrun;

    modport master (
        input  k_row,
        input  k_col,
        input  key_ack,
        input  clr_ovr,
        output row_out,
        output col_out,
        output key_valid,
        output key_code,
        output pressed,
        output overrun
    );

    modport slave (
        output k_row,
        output k_col,
        output key_ack,
        output clr_ovr,
        input  row_out,
        input  col_out,
        input  key_valid,
        input  key_code,
        input  pressed,
        input  overrun
    );
endinterface

// File: rtl/keypad_debounce.sv
// Keypad matrix debouncer: synchronizes raw rows/columns, accepts a value after STABLE_N
// equal slow-tick samples, and reports single-key presses through a valid/ack handshake.
module keypad_debounce #(
    parameter int ROWS       = 5,
    parameter int COLS       = 4,
    parameter int SAMPLE_DIV = 100000,
    parameter int STABLE_N   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    keypad_debounce_if.master kp
);
    localparam int CW = $clog2(ROWS * COLS);
    localparam int NW = ROWS + COLS;

    localparam logic [NW-1:0] ALL_ONES    = '1;
    localparam logic [31:0]   DIV_LAST    = 32'(SAMPLE_DIV - 1);
    localparam logic [3:0]    STAB_SAT    = 4'(STABLE_N);
    localparam logic [3:0]    STAB_ACCEPT = 4'(STABLE_N - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HELD = 1'b1;

    // Rows occupy the upper bits, columns the lower bits of every packed sample.
    logic [NW-1:0] meta_reg;
    logic [NW-1:0] sync_reg;

    logic [31:0]   div_reg;
    logic          tick;

    logic [NW-1:0] prev_reg;
    logic [3:0]    stab_reg;
    logic [NW-1:0] deb_reg;
    logic          accept;

    logic [ROWS-1:0] cand_rows;
    logic [COLS-1:0] cand_cols;
    logic            single_key;
    int              row_idx;
    int              col_idx;
    logic [CW-1:0]   code_new;

    logic [0:0]    state_reg;
    logic [0:0]    state_next;
    logic          press_event;

    logic          valid_reg;
    logic          valid_next;
    logic [CW-1:0] code_reg;
    logic [CW-1:0] code_next;
    logic          ovr_reg;
    logic          ovr_next;
    logic          drop;

    // Two-flop synchronizer for the asynchronous keypad lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= ALL_ONES;
            sync_reg <= ALL_ONES;
        end else begin
            meta_reg <= {kp.k_row, kp.k_col};
            sync_reg <= meta_reg;
        end
    end

    assign tick = (div_reg == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_reg <= '0;
        end else if (tick) begin
            div_reg <= '0;
        end else begin
            div_reg <= div_reg + 32'd1;
        end
    end

    // stab_reg counts equal samples after the capture tick and parks at STABLE_N,
    // so a steady value is accepted exactly once per change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_reg <= ALL_ONES;
            stab_reg <= '0;
            deb_reg  <= ALL_ONES;
        end else if (tick) begin
            if (sync_reg != prev_reg) begin
                prev_reg <= sync_reg;
                stab_reg <= '0;
            end else if (stab_reg < STAB_SAT) begin
                stab_reg <= stab_reg + 4'd1;
                if (stab_reg == STAB_ACCEPT) begin
                    deb_reg <= prev_reg;
                end
            end
        end
    end

    assign accept = tick && (sync_reg == prev_reg) && (stab_reg == STAB_ACCEPT);

    // Decode the value being accepted this cycle (it is prev_reg, about to land in deb_reg).
    assign cand_rows  = prev_reg[NW-1:COLS];
    assign cand_cols  = prev_reg[COLS-1:0];
    assign single_key = $onehot(~cand_rows) && $onehot(~cand_cols);

    always_comb begin
        row_idx = 0;
        for (int i = 0; i < ROWS; i++) begin
            if (!cand_rows[i]) begin
                row_idx = i;
            end
        end
    end

    always_comb begin
        col_idx = 0;
        for (int i = 0; i < COLS; i++) begin
            if (!cand_cols[i]) begin
                col_idx = i;
            end
        end
    end

    assign code_new = CW'(row_idx * COLS + col_idx);

    // Ghost and multi-key patterns still move to HELD, they just never raise an event.
    always_comb begin
        state_next  = state_reg;
        press_event = 1'b0;
        if (accept) begin
            case (state_reg)
                ST_IDLE: begin
                    if (prev_reg != ALL_ONES) begin
                        state_next  = ST_HELD;
                        press_event = single_key;
                    end
                end
                ST_HELD: begin
                    if (prev_reg == ALL_ONES) begin
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        valid_next = valid_reg;
        code_next  = code_reg;
        drop       = 1'b0;
        if (press_event) begin
            if (!valid_reg || kp.key_ack) begin
                code_next  = code_new;
                valid_next = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end else if (valid_reg && kp.key_ack) begin
            valid_next = 1'b0;
        end
    end

    // A drop in the same cycle as clr_ovr keeps the flag set.
    always_comb begin
        ovr_next = ovr_reg;
        if (drop) begin
            ovr_next = 1'b1;
        end else if (kp.clr_ovr) begin
            ovr_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            valid_reg <= 1'b0;
            code_reg  <= '0;
            ovr_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            valid_reg <= valid_next;
            code_reg  <= code_next;
            ovr_reg   <= ovr_next;
        end
    end

    assign kp.row_out   = deb_reg[NW-1:COLS];
    assign kp.col_out   = deb_reg[COLS-1:0];
    assign kp.pressed   = (state_reg == ST_HELD);
    assign kp.key_valid = valid_reg;
    assign kp.key_code  = code_reg;
    assign kp.overrun   = ovr_reg;

endmodule

// File: tb/tb_keypad_debounce.sv
// Bench for keypad_debounce: directed vector table, timed corner sequences and random
// stimulus, all compared every cycle against a sample-run reference model.
module tb_keypad_debounce;
    localparam int ROWS = 5;
    localparam int COLS = 4;
    localparam int SD   = 4;
    localparam int SN   = 3;
    localparam int NW   = ROWS + COLS;
    localparam logic [NW-1:0] ONES = '1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    keypad_debounce_if #(.ROWS(ROWS), .COLS(COLS)) kp ();

    keypad_debounce #(
        .ROWS(ROWS), .COLS(COLS), .SAMPLE_DIV(SD), .STABLE_N(SN)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .kp   (kp.master)
    );

    always #5 clk = ~clk;

    // Reference model: raw values reach the sampler two clocks late; a value is accepted
    // when the run of equal tick samples (reset counts as one all-ones sample) reaches SN+1.
    logic [NW-1:0] q[$];
    int            edge_n;
    logic [NW-1:0] run_val;
    int            run_len;
    logic [NW-1:0] m_deb;
    bit            m_held;
    bit            m_valid;
    int            m_code;
    bit            m_ovr;

    function automatic bit is_single(input logic [NW-1:0] v);
        logic [ROWS-1:0] rl;
        logic [COLS-1:0] cl;
        rl = ~v[NW-1:COLS];
        cl = ~v[COLS-1:0];
        return ($countones(rl) == 1) && ($countones(cl) == 1);
    endfunction

    function automatic int code_of(input logic [NW-1:0] v);
        logic [ROWS-1:0] rl;
        logic [COLS-1:0] cl;
        rl = ~v[NW-1:COLS];
        cl = ~v[COLS-1:0];
        return $clog2(rl) * COLS + $clog2(cl);
    endfunction

    task automatic model_reset();
        q.delete();
        q.push_back(ONES);
        q.push_back(ONES);
        edge_n  = 0;
        run_val = ONES;
        run_len = 1;
        m_deb   = ONES;
        m_held  = 0;
        m_valid = 0;
        m_code  = 0;
        m_ovr   = 0;
    endtask

    function automatic bit peek_event();
        logic [NW-1:0] s;
        if ((edge_n % SD) != SD - 1) return 0;
        s = q[0];
        if (s != run_val || run_len + 1 != SN + 1) return 0;
        return !m_held && (s != ONES) && is_single(s);
    endfunction

    task automatic model_edge(input logic [NW-1:0] raw, input bit ack, input bit clr);
        logic [NW-1:0] s;
        bit tick, acc, ev, drop;
        s = q.pop_front();
        q.push_back(raw);
        tick = ((edge_n % SD) == SD - 1);
        edge_n++;
        acc = 0;
        if (tick) begin
            if (s == run_val) begin
                run_len++;
                if (run_len == SN + 1) begin
                    acc   = 1;
                    m_deb = s;
                end
            end else begin
                run_val = s;
                run_len = 1;
            end
        end
        ev = 0;
        if (acc) begin
            if (!m_held && s != ONES) begin
                m_held = 1;
                ev     = is_single(s);
            end else if (m_held && s == ONES) begin
                m_held = 0;
            end
        end
        drop = 0;
        if (ev) begin
            if (!m_valid || ack) begin
                m_code  = code_of(s);
                m_valid = 1;
            end else begin
                drop = 1;
            end
        end else if (m_valid && ack) begin
            m_valid = 0;
        end
        if (drop) m_ovr = 1;
        else if (clr) m_ovr = 0;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("row_out",   int'(kp.row_out),   int'(m_deb[NW-1:COLS]));
        chk("col_out",   int'(kp.col_out),   int'(m_deb[COLS-1:0]));
        chk("pressed",   int'(kp.pressed),   int'(m_held));
        chk("key_valid", int'(kp.key_valid), int'(m_valid));
        chk("key_code",  int'(kp.key_code),  m_code);
        chk("overrun",   int'(kp.overrun),   int'(m_ovr));
    endtask

    // One clock: drive at the falling edge, let the rising edge act, check at the next falling edge.
    task automatic cyc(input logic [ROWS-1:0] r, input logic [COLS-1:0] c, input bit ack, input bit clr);
        kp.k_row   = r;
        kp.k_col   = c;
        kp.key_ack = ack;
        kp.clr_ovr = clr;
        model_edge({r, c}, ack, clr);
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset();
        kp.k_row   = '1;
        kp.k_col   = '1;
        kp.key_ack = 1'b0;
        kp.clr_ovr = 1'b0;
        rst_n      = 1'b0;
        #1;
        model_reset();
        chk("rst_row_out",   int'(kp.row_out),   31);
        chk("rst_col_out",   int'(kp.col_out),   15);
        chk("rst_pressed",   int'(kp.pressed),   0);
        chk("rst_key_valid", int'(kp.key_valid), 0);
        chk("rst_key_code",  int'(kp.key_code),  0);
        chk("rst_overrun",   int'(kp.overrun),   0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Press applied right at reset release: first tick on edge 3, accept on edge 15.
    task automatic press_latency(input string tag);
        for (int k = 0; k < 15; k++) cyc(5'b11011, 4'b1101, 1'b0, 1'b0);
        chk({tag, "_row_early"}, int'(kp.row_out), 31);
        cyc(5'b11011, 4'b1101, 1'b0, 1'b0);
        chk({tag, "_row_out"},   int'(kp.row_out),   27);
        chk({tag, "_col_out"},   int'(kp.col_out),   13);
        chk({tag, "_pressed"},   int'(kp.pressed),   1);
        chk({tag, "_key_valid"}, int'(kp.key_valid), 1);
        chk({tag, "_key_code"},  int'(kp.key_code),  9);
    endtask

    typedef struct {
        logic [ROWS-1:0] row;
        logic [COLS-1:0] col;
        bit              ack;
        bit              clr;
        int              cycles;
        logic [ROWS-1:0] e_row;
        logic [COLS-1:0] e_col;
        bit              e_pressed;
        bit              e_valid;
        int              e_code;
        bit              e_ovr;
    } vec_t;

    vec_t tbl[11];

    initial begin
        bit            found;
        logic [ROWS-1:0] r;
        logic [COLS-1:0] c;
        logic [NW-1:0]   v;

        tbl[0]  = '{5'b11111, 4'b1111, 1'b0, 1'b0,  8, 5'b11111, 4'b1111, 1'b0, 1'b0, 0, 1'b0};
        tbl[1]  = '{5'b11011, 4'b1101, 1'b0, 1'b0, 24, 5'b11011, 4'b1101, 1'b1, 1'b1, 9, 1'b0};
        tbl[2]  = '{5'b11111, 4'b1111, 1'b0, 1'b0, 24, 5'b11111, 4'b1111, 1'b0, 1'b1, 9, 1'b0};
        tbl[3]  = '{5'b11110, 4'b1110, 1'b0, 1'b0, 24, 5'b11110, 4'b1110, 1'b1, 1'b1, 9, 1'b1};
        tbl[4]  = '{5'b11111, 4'b1111, 1'b0, 1'b0, 24, 5'b11111, 4'b1111, 1'b0, 1'b1, 9, 1'b1};
        tbl[5]  = '{5'b11111, 4'b1111, 1'b0, 1'b1,  1, 5'b11111, 4'b1111, 1'b0, 1'b1, 9, 1'b0};
        tbl[6]  = '{5'b11111, 4'b1111, 1'b1, 1'b0,  1, 5'b11111, 4'b1111, 1'b0, 1'b0, 9, 1'b0};
        tbl[7]  = '{5'b11001, 4'b1101, 1'b0, 1'b0, 24, 5'b11001, 4'b1101, 1'b1, 1'b0, 9, 1'b0};
        tbl[8]  = '{5'b11111, 4'b1111, 1'b0, 1'b0, 24, 5'b11111, 4'b1111, 1'b0, 1'b0, 9, 1'b0};
        tbl[9]  = '{5'b11110, 4'b1110, 1'b0, 1'b0, 24, 5'b11110, 4'b1110, 1'b1, 1'b1, 0, 1'b0};
        tbl[10] = '{5'b11111, 4'b1111, 1'b0, 1'b0, 24, 5'b11111, 4'b1111, 1'b0, 1'b1, 0, 1'b0};

        kp.k_row = '1;
        kp.k_col = '1;
        kp.key_ack = 1'b0;
        kp.clr_ovr = 1'b0;
        #2;
        do_reset();

        // Exact accept latency, then reset in the middle of a release debounce.
        press_latency("lat");
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            cyc(5'b11111, 4'b1111, 1'b0, 1'b0);
            if (run_val == ONES && run_len == 3) found = 1;
        end
        chk("mid_debounce_reached", int'(found), 1);
        chk("mid_debounce_valid", int'(kp.key_valid), 1);
        do_reset();
        press_latency("post_rst");
        for (int k = 0; k < 24; k++) cyc(5'b11111, 4'b1111, 1'b0, 1'b0);
        do_reset();

        for (int i = 0; i < 11; i++) begin
            for (int k = 0; k < tbl[i].cycles; k++)
                cyc(tbl[i].row, tbl[i].col, tbl[i].ack, tbl[i].clr);
            chk($sformatf("vec%0d_row_out", i),   int'(kp.row_out),   int'(tbl[i].e_row));
            chk($sformatf("vec%0d_col_out", i),   int'(kp.col_out),   int'(tbl[i].e_col));
            chk($sformatf("vec%0d_pressed", i),   int'(kp.pressed),   int'(tbl[i].e_pressed));
            chk($sformatf("vec%0d_key_valid", i), int'(kp.key_valid), int'(tbl[i].e_valid));
            chk($sformatf("vec%0d_key_code", i),  int'(kp.key_code),  tbl[i].e_code);
            chk($sformatf("vec%0d_overrun", i),   int'(kp.overrun),   int'(tbl[i].e_ovr));
        end

        // Press event landing on the same edge as key_ack while an older code is pending.
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (peek_event()) begin
                cyc(5'b10111, 4'b0111, 1'b1, 1'b0);
                found = 1;
            end else begin
                cyc(5'b10111, 4'b0111, 1'b0, 1'b0);
            end
        end
        chk("ack_event_reached", int'(found), 1);
        chk("ack_event_valid",   int'(kp.key_valid), 1);
        chk("ack_event_code",    int'(kp.key_code), 15);
        chk("ack_event_overrun", int'(kp.overrun), 0);
        for (int k = 0; k < 24; k++) cyc(5'b11111, 4'b1111, 1'b0, 1'b0);

        // Bounce every two ticks: nothing may ever be accepted.
        do_reset();
        for (int k = 0; k < 80; k++) begin
            if (((k / 8) % 2) == 0) cyc(5'b11011, 4'b1101, 1'b0, 1'b0);
            else                    cyc(5'b11111, 4'b1111, 1'b0, 1'b0);
            chk("bounce_row_out",   int'(kp.row_out), 31);
            chk("bounce_col_out",   int'(kp.col_out), 15);
            chk("bounce_key_valid", int'(kp.key_valid), 0);
        end
        for (int k = 0; k < 24; k++) cyc(5'b11111, 4'b1111, 1'b0, 1'b0);

        // Random segments of idle, clean keys, arbitrary patterns and per-cycle chatter.
        for (int seg = 0; seg < 150; seg++) begin
            int kind;
            int len;
            kind = $urandom_range(0, 3);
            len  = $urandom_range(1, 30);
            r = '1;
            c = '1;
            if (kind == 1) begin
                r[$urandom_range(0, ROWS - 1)] = 1'b0;
                c[$urandom_range(0, COLS - 1)] = 1'b0;
            end else if (kind == 2) begin
                v = NW'($urandom);
                r = v[NW-1:COLS];
                c = v[COLS-1:0];
            end
            for (int k = 0; k < len; k++) begin
                if (kind == 3) begin
                    v = NW'($urandom);
                    r = v[NW-1:COLS];
                    c = v[COLS-1:0];
                end
                cyc(r, c, ($urandom % 4) == 0, ($urandom % 8) == 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
